// File: rtl/lbp_interp_seq.sv
// Time-shared bilinear interpolation stage for the LBP pipeline: P circular-neighbour
// samples per pixel, LANES weighted 4-corner sums per CALC cycle, weights from a table.
module lbp_interp_seq #(
    parameter int P     = 8,
    parameter int LANES = 4,
    parameter int DW    = 8,
    parameter int FRAC  = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [P*4*DW-1:0]          corners_i,
    input  logic                       done_i,
    input  logic                       progress_done_i,
    input  logic                       cfg_we,
    input  logic [$clog2(4*P)-1:0]     cfg_addr,
    input  logic [FRAC:0]              cfg_data,
    output logic                       cfg_busy,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [P*(DW+FRAC)-1:0]     samples_o,
    output logic                       done_o,
    output logic                       progress_done_o,
    output logic [1:0]                 dbg_state
);
    localparam int G  = P / LANES;
    localparam int OW = DW + FRAC;
    localparam int AW = OW + 3;
    localparam int WW = FRAC + 1;
    localparam int NE = 4 * P;
    localparam int PW = $clog2(P);
    localparam int AD = $clog2(NE);
    localparam int GW = (G > 1) ? $clog2(G) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_OUT  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [GW-1:0]     g_q;
    logic [P*4*DW-1:0] corner_q;
    logic              done_q, prog_q;
    logic              accept;
    logic              last_calc;

    logic [WW-1:0]     wt_q [NE];
    logic              pend_q;
    logic [AD-1:0]     pend_addr_q;
    logic [WW-1:0]     pend_data_q;

    logic [DW-1:0]     corner_arr [NE];
    logic [OW-1:0]     samples_arr [P];
    logic [PW-1:0]     pt [LANES];
    logic [AW-1:0]     acc [LANES];
    logic [OW-1:0]     lane_res [LANES];

    // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
    // valid never depends on ready, and ready in OUT is the downstream ready passed through.
    always_comb begin
        state_d  = state_q;
        in_ready = 1'b0;
        case (state_q)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_d = S_CALC;
            end
            S_CALC: begin
                if (g_q == GW'(G - 1)) state_d = S_OUT;
            end
            S_OUT: begin
                in_ready = out_ready;
                if (out_ready) state_d = in_valid ? S_CALC : S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign accept    = in_valid & in_ready;
    assign last_calc = (state_q == S_CALC) && (g_q == GW'(G - 1));
    assign out_valid = (state_q == S_OUT);
    assign cfg_busy  = (state_q != S_IDLE);
    assign done_o          = out_valid & done_q;
    assign progress_done_o = out_valid & prog_q;
    assign dbg_state = state_q;

    for (genvar i = 0; i < NE; i++) begin : g_corner
        assign corner_arr[i] = corner_q[i*DW +: DW];
    end

    for (genvar j = 0; j < P; j++) begin : g_sample
        assign samples_o[j*OW +: OW] = samples_arr[j];
    end

    // Point j of the current group lives at table/corner entries {j, c}.
    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            pt[l]  = PW'(int'(g_q) * LANES + l);
            acc[l] = '0;
            for (int c = 0; c < 4; c++) begin
                acc[l] = acc[l] + AW'(wt_q[{pt[l], 2'(c)}]) * AW'(corner_arr[{pt[l], 2'(c)}]);
            end
            lane_res[l] = (acc[l] >= (AW'(1) << OW)) ? '1 : acc[l][OW-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            g_q      <= '0;
            corner_q <= '0;
            done_q   <= 1'b0;
            prog_q   <= 1'b0;
            for (int j = 0; j < P; j++) samples_arr[j] <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                corner_q <= corners_i;
                done_q   <= done_i;
                prog_q   <= progress_done_i;
                g_q      <= '0;
            end else if (state_q == S_CALC) begin
                g_q <= g_q + GW'(1);
            end
            if (state_q == S_CALC) begin
                for (int l = 0; l < LANES; l++) samples_arr[pt[l]] <= lane_res[l];
            end
        end
    end

    // A write arriving with an accept is parked and lands after that pixel's last CALC cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NE; i++) wt_q[i] <= ((i % 4) == 0) ? WW'(1 << FRAC) : '0;
            pend_q      <= 1'b0;
            pend_addr_q <= '0;
            pend_data_q <= '0;
        end else begin
            if (cfg_we && (state_q == S_IDLE)) begin
                if (accept) begin
                    pend_q      <= 1'b1;
                    pend_addr_q <= cfg_addr;
                    pend_data_q <= cfg_data;
                end else begin
                    wt_q[cfg_addr] <= cfg_data;
                end
            end
            if (pend_q && last_calc) begin
                wt_q[pend_addr_q] <= pend_data_q;
                pend_q            <= 1'b0;
            end
        end
    end

endmodule
